// File: rtl/data_mem_responder_pkg.sv
// Shared types and decode helpers for the data memory responder:
// access modes, FSM states, alignment and lane-enable decode.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_HALF = 2'b01,
    MODE_WORD = 2'b11
  } mem_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } resp_state_t;

  localparam int CNT_W = 4;

  // Mode 2'b10 is not a legal size, so it is reported like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] lo);
    case (mode)
      MODE_BYTE: return 1'b0;
      MODE_HALF: return lo[0];
      MODE_WORD: return (lo != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] mode, input logic [1:0] lo);
    case (mode)
      MODE_BYTE: return 4'b0001 << lo;
      MODE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      MODE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Word-organised data RAM built from four byte lanes: synchronous
// byte-enable write, combinational read of the same word index.
module data_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[widx] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[widx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data responder: captures one load/store, spends LATENCY
// cycles in ACCESS, then pulses resp_valid for one cycle with aligned load data.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_wen,
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  resp_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             wen_reg;
  logic [1:0]       mode_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;

  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        unused_addr;

  // Address bits above the word index only alias onto the same RAM words.
  assign unused_addr = ^addr_reg[31:AW+2];

  assign stall  = ((state_reg == ST_IDLE) && mem_en) || (state_reg == ST_ACCESS);
  assign ram_we = (state_reg == ST_ACCESS) && (cnt_reg == '0) && wen_reg;
  assign ram_be = lane_enables(mode_reg, addr_reg[1:0]);
  assign shifted = ram_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    ram_wdata = wdata_reg;
    load_data = shifted;
    case (mode_reg)
      MODE_BYTE: begin
        ram_wdata = {4{wdata_reg[7:0]}};
        load_data = {24'h0, shifted[7:0]};
      end
      MODE_HALF: begin
        ram_wdata = {2{wdata_reg[15:0]}};
        load_data = {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

  data_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .widx  (addr_reg[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      wen_reg    <= 1'b0;
      mode_reg   <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      resp_valid <= 1'b0;
      addr_err   <= 1'b0;
      rdata      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mem_en) begin
            wen_reg   <= mem_wen;
            mode_reg  <= mode;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            if (is_misaligned(mode, addr[1:0])) begin
              state_reg  <= ST_RESP;
              resp_valid <= 1'b1;
              addr_err   <= 1'b1;
              rdata      <= '0;
            end else begin
              state_reg <= ST_ACCESS;
              cnt_reg   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_reg == '0) begin
            state_reg  <= ST_RESP;
            resp_valid <= 1'b1;
            addr_err   <= 1'b0;
            rdata      <= wen_reg ? 32'h0 : load_data;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_RESP: begin
          state_reg  <= ST_IDLE;
          resp_valid <= 1'b0;
          addr_err   <= 1'b0;
          rdata      <= '0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table,
// hand-written reset/back-to-back sequences, then randomized traffic vs a byte-array model.
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en = 1'b0;
  logic        mem_wen = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [4096];

  typedef struct {
    logic        wen;
    logic [1:0]  md;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[19];

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mode       (mode),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  function automatic int access_size(input logic [1:0] md);
    return (md == 2'b00) ? 1 : (md == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_bad(input logic [1:0] md, input logic [31:0] a);
    return (md == 2'b10) || ((a % access_size(md)) != 0);
  endfunction

  task automatic model_store(input logic [1:0] md, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < access_size(md); i++) model_mem[12'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] md, input logic [31:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < access_size(md); i++) v |= 32'(model_mem[12'(a + 32'(i))]) << (8 * i);
    return v;
  endfunction

  // One complete request: present for one cycle, scramble inputs after capture,
  // then watch stall/outputs each cycle until the response pulse.
  task automatic do_req(input logic wen, input logic [1:0] md, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got_rd, output logic got_err);
    int  exp_lat;
    bit  seen;
    exp_lat = model_bad(md, a) ? 1 : LATENCY + 1;
    seen    = 0;
    got_rd  = '0;
    got_err = 1'b0;
    @(negedge clk);
    mem_en = 1'b1; mem_wen = wen; mode = md; addr = a; wdata = wd;
    #1 check("stall_on_request", 32'(stall), 32'd1);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mem_en = 1'b0; mem_wen = 1'($urandom); mode = 2'($urandom);
        addr = $urandom; wdata = $urandom;
      end
      #1;
      if (resp_valid) begin
        seen    = 1;
        got_rd  = rdata;
        got_err = addr_err;
        check($sformatf("latency a=%h md=%b", a, md), 32'(k), 32'(exp_lat));
        check("stall_in_resp", 32'(stall), 32'd0);
      end else begin
        check("stall_in_access", 32'(stall), 32'(k < exp_lat));
        check("quiet_outputs", {rdata[30:0], addr_err}, 32'd0);
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got no resp_valid in 20 cycles, expected one at cycle %0d", exp_lat);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  logic        rv_seen;

  initial begin
    vecs[0]  = '{1'b1, 2'b11, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b11, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b11, 32'h10,   32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 2'b00, 32'h13,   32'h000000AA, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'b11, 32'h10,   32'h0,        32'hAA223344, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 32'h13,   32'h0,        32'h000000AA, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 32'h12,   32'h0,        32'h0000AA22, 1'b0};
    vecs[7]  = '{1'b1, 2'b11, 32'h20,   32'hCAFEF00D, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 2'b11, 32'h21,   32'h12345678, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 2'b11, 32'h20,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b1, 2'b11, 32'h0,    32'h0BADC0DE, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 2'b11, 32'h1000, 32'h0,        32'h0BADC0DE, 1'b0};
    vecs[12] = '{1'b0, 2'b10, 32'h0,    32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 2'b01, 32'h11,   32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 2'b01, 32'h2,    32'hFFFF5566, 32'h0,        1'b0};
    vecs[15] = '{1'b1, 2'b00, 32'h1,    32'hFFFFFF77, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 2'b11, 32'h0,    32'h0,        32'h556677DE, 1'b0};
    vecs[17] = '{1'b0, 2'b00, 32'h2,    32'h0,        32'h00000066, 1'b0};
    vecs[18] = '{1'b0, 2'b01, 32'h0,    32'h0,        32'h000077DE, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_addr_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 19; i++) begin
      do_req(vecs[i].wen, vecs[i].md, vecs[i].a, vecs[i].wd, rd, er);
      $display("vec %0d wen=%b mode=%b addr=%h wdata=%h -> rdata=%h err=%b",
               i, vecs[i].wen, vecs[i].md, vecs[i].a, vecs[i].wd, rd, er);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      if (!vecs[i].wen || vecs[i].exp_err)
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Back-to-back: mem_en held high, second request accepted right after RESP
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 1'b0; mode = 2'b11; addr = 32'h10; wdata = '0;
    #1 check("b2b_stall_c0", 32'(stall), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("b2b_stall_c%0d", k), 32'(stall), 32'((k == 3 || k == 7) ? 0 : 1));
      check($sformatf("b2b_resp_c%0d", k), 32'(resp_valid), 32'(k == 3 || k == 7));
      if (resp_valid) check($sformatf("b2b_rdata_c%0d", k), rdata, 32'hAA223344);
      if (k == 7) mem_en = 1'b0;
    end
    $display("back-to-back loads at 0x10 done");

    // Reset in the middle of a store's ACCESS phase
    do_req(1'b1, 2'b11, 32'h30, 32'h11111111, rd, er);
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 1'b1; mode = 2'b11; addr = 32'h30; wdata = 32'h99999999;
    @(negedge clk);
    mem_en = 1'b0;
    #1 check("abort_stall_access", 32'(stall), 32'd1);
    reset = 1'b1;
    #1 check("abort_stall_idle", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rv_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 rv_seen |= resp_valid;
    end
    check("abort_no_resp", 32'(rv_seen), 32'd0);
    do_req(1'b0, 2'b11, 32'h30, 32'h0, rd, er);
    $display("reset-abort store at 0x30 -> reload rdata=%h", rd);
    check("abort_no_write", rd, 32'h11111111);

    // Randomized traffic over a 16-word window with aliased upper address bits
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d = $urandom;
      do_req(1'b1, 2'b11, 32'(w * 4), d, rd, er);
      model_store(2'b11, 32'(w * 4), d);
      check($sformatf("init%0d_err", w), 32'(er), 32'd0);
    end
    for (int t = 0; t < 250; t++) begin
      logic        w_en = 1'($urandom);
      logic [1:0]  md   = 2'($urandom_range(0, 3));
      logic [31:0] a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2)
                          | 32'($urandom_range(0, 3));
      logic [31:0] d    = $urandom;
      logic        bad  = model_bad(md, a);
      logic [31:0] exp_rd = (bad || w_en) ? 32'h0 : model_load(md, a);
      do_req(w_en, md, a, d, rd, er);
      $display("rnd %0d wen=%b mode=%b addr=%h wdata=%h -> rdata=%h err=%b", t, w_en, md, a, d, rd, er);
      check($sformatf("rnd%0d_err", t), 32'(er), 32'(bad));
      if (!w_en || bad) check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      if (w_en && !bad) model_store(md, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles spent in ACCESS, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_en  input  1  request present: a load or store is being issued by the memory stage.
REQ-006 SHALL have port mem_wen  input  1  1 = store, 0 = load.
REQ-007 SHALL have port mode  input  2  00 byte, 01 halfword, 11 word, 10 illegal.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port stall  output  1  memory stage must hold its request this cycle.
REQ-011 SHALL have port resp_valid  output  1  one-cycle pulse, response complete.
REQ-012 SHALL have port rdata  output  32  load data, right-aligned, unselected upper bits zero.
REQ-013 SHALL have port addr_err  output  1  valid with resp_valid: misaligned or illegal-mode access.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 In IDLE, mem_en=1 SHALL capture mem_wen, mode, addr, wdata into internal registers at the next edge.
REQ-016 An aligned captured request SHALL move IDLE->ACCESS and load the counter with LATENCY-1.
REQ-017 A misaligned request SHALL move IDLE->RESP directly, with no RAM access and no write.
- Misaligned = mode 01 with addr[0]=1, mode 11 with addr[1:0]!=0, or mode 10.
REQ-018 ACCESS SHALL decrement the counter each cycle and go to RESP when the counter is 0 (exactly LATENCY cycles in ACCESS).
REQ-019 RESP SHALL last exactly one cycle, assert resp_valid=1, then return to IDLE unconditionally.
REQ-020 stall SHALL be combinational: 1 in (IDLE and mem_en) and in ACCESS; 0 in RESP and in idle IDLE.
REQ-021 An aligned load SHALL therefore have total latency LATENCY+1 cycles from the first mem_en cycle to resp_valid, inclusive.
REQ-022 mem_en in the cycle after RESP SHALL be treated as a new request.
REQ-023 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-024 Store byte enables SHALL be decoded from captured mode and addr[1:0]:
- byte: single lane addr[1:0].
- half: lanes {1,0} or {3,2} per addr[1].
- word: all four lanes.
REQ-025 Store data SHALL be steered into the lanes: byte replicated x4, half replicated x2.
REQ-026 The store SHALL commit on the ACCESS->RESP edge only, exactly once per request.
REQ-027 Load rdata SHALL be the word read in the final ACCESS cycle, shifted right by 8*addr[1:0], masked to 8/16/32 bits by mode, and held stable through RESP.
REQ-028 rdata SHALL be 0 and addr_err SHALL be 0 whenever resp_valid=0.
REQ-029 In an error response, rdata SHALL be 0 and addr_err SHALL be 1.
REQ-030 Changes on the inputs after capture SHALL not affect the in-flight request.

Reset
REQ-031 reset SHALL force the state to IDLE, the counter to 0, all capture registers to 0, and resp_valid, addr_err and rdata to 0, asynchronously.
REQ-032 Reset during ACCESS SHALL abort the request with no write and no response.
REQ-033 RAM contents SHALL NOT be reset.

Structure
REQ-034 Shared package SHALL hold the mem_mode_t enum (MODE_BYTE=00, MODE_HALF=01, MODE_WORD=11) and the responder state enum.
REQ-035 Storage SHALL be a sub-module data_ram: DEPTH_WORDS x 32, synchronous byte-enable write, combinational read.

Verification
REQ-036 Word store then load, LATENCY=2:
- Store addr 0x10, wdata 0xDEADBEEF -> resp_valid in cycle 3.
- Load addr 0x10 -> rdata 0xDEADBEEF, stall high in cycles 0-2.
REQ-037 Byte store to addr 0x13, wdata 0x000000AA, over word 0x11223344 -> word load returns 0xAA223344; byte load at 0x13 returns 0x000000AA.
REQ-038 Half load at addr 0x12 of 0xAA223344 -> 0x0000AA22.
REQ-039 Misaligned word store at 0x21 -> resp_valid in cycle 1 with addr_err=1, rdata=0; memory at 0x20 unchanged.
REQ-040 Reset asserted mid-ACCESS of a store -> no write occurs, state IDLE, no resp_valid.
REQ-041 Wrap and back-to-back:
- Load at addr 0x1000 (DEPTH_WORDS=1024) -> same data as addr 0x0.
- mem_en held high -> two responses, the next request accepted the cycle after RESP.
